// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM states, frame width and default bit period.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam int DATA_BITS            = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 10417;

endpackage

// File: rtl/uart_rx_sampler_if.sv
// Receive-side consumer handshake: holding register, status flags and ack.
interface uart_rx_sampler_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_data_avail;
    logic                 rx_overrun;
    logic                 rx_frame_err;
    logic                 rx_parity_err;
    logic                 rx_busy;
    logic                 rx_ack;

    modport master (
        output rx_data, rx_data_avail, rx_overrun, rx_frame_err, rx_parity_err, rx_busy,
        input  rx_ack
    );

    modport slave (
        input  rx_data, rx_data_avail, rx_overrun, rx_frame_err, rx_parity_err, rx_busy,
        output rx_ack
    );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous input; both flops reset to 1 (idle-high lines).
module uart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_sampler.sv
// 8N1 UART receiver with one-deep holding register and avail/ack handshake.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                clk_100mhz,
    input  logic                btn_reset,
    input  logic                uart_rxd_in,
    uart_rx_sampler_if.master   bus
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT);
    localparam int BW       = $clog2(DATA_BITS);

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_BITS - 1);

    logic                 rxs;
    uart_state_t          state;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] data_r;
    logic                 avail_r;
    logic                 overrun_r;
    logic                 frame_err_r;
    logic                 busy_r;
    logic                 par_ok;

    uart_sync2 u_sync (
        .clk (clk_100mhz),
        .rst (btn_reset),
        .d   (uart_rxd_in),
        .q   (rxs)
    );

`ifdef UART_RX_PARITY_EN
    logic parity_err_r;
    logic par_bad;

    assign par_ok            = ~par_bad;
    assign bus.rx_parity_err = parity_err_r;
`else
    assign par_ok            = 1'b1;
    assign bus.rx_parity_err = 1'b0;
`endif

    always_ff @(posedge clk_100mhz or posedge btn_reset) begin
        if (btn_reset) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            data_r       <= '0;
            avail_r      <= 1'b0;
            overrun_r    <= 1'b0;
            frame_err_r  <= 1'b0;
            busy_r       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_r <= 1'b0;
            par_bad      <= 1'b0;
`endif
        end else begin
            frame_err_r  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_r <= 1'b0;
`endif
            // Ack is applied first so a coincident commit below wins on avail.
            if (bus.rx_ack) begin
                avail_r   <= 1'b0;
                overrun_r <= 1'b0;
            end

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rxs) begin
                        state  <= START;
                        busy_r <= 1'b1;
                    end
                end

                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!rxs) begin
                            state   <= DATA;
                            bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                            par_bad <= 1'b0;
`endif
                        end else begin
                            state  <= IDLE;
                            busy_r <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        shreg <= {rxs, shreg[DATA_BITS-1:1]};
                        if (bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + BW'(1);
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= STOP;
                        if (rxs != ^shreg) begin
                            parity_err_r <= 1'b1;
                            par_bad      <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`endif

                STOP: begin
                    if (cnt == BIT_LAST) begin
                        // Leave mid stop bit so a back-to-back start edge is not missed.
                        cnt    <= '0;
                        state  <= IDLE;
                        busy_r <= 1'b0;
                        if (!rxs) begin
                            frame_err_r <= 1'b1;
                        end else if (par_ok) begin
                            data_r  <= shreg;
                            avail_r <= 1'b1;
                            if (avail_r && !bus.rx_ack) begin
                                overrun_r <= 1'b1;
                            end
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_data       = data_r;
    assign bus.rx_data_avail = avail_r;
    assign bus.rx_overrun    = overrun_r;
    assign bus.rx_frame_err  = frame_err_r;
    assign bus.rx_busy       = busy_r;

endmodule
